// File: rtl/eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eval_pkg
//  Description : Shared constants and encodings for the evaluation scheduler:
//                batch/board geometry, evaluation width, scheduler state and
//                per-engine slot state, plus the signed "beats" compare.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package eval_pkg;

  localparam int MAX_BOARDS = 7;
  localparam int SLOT_BITS  = 88;
  localparam int BOARD_BITS = 84;
  localparam int EVAL_WIDTH = 32;
  localparam int BATCH_BITS = MAX_BOARDS * SLOT_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    ENG_FREE    = 2'd0,
    ENG_BUSY    = 2'd1,
    ENG_RECYCLE = 2'd2
  } eng_state_t;

  // Strict signed comparison: ties never displace the current best.
  function automatic logic beats(input logic signed [EVAL_WIDTH-1:0] cand,
                                 input logic signed [EVAL_WIDTH-1:0] best,
                                 input logic                         is_max);
    return is_max ? (cand > best) : (cand < best);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eval_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : eval_scheduler_if
//  Description : Host-side (SPI receive/send) and engine-side signals of the
//                evaluation scheduler.
//  Ports       : batch request  : start, is_max, batch_size, batch
//                batch status   : busy, done, result, result_valid, err
//                engine side    : eng_board, eng_enable, eng_reset (active low),
//                                 eng_stable, eng_eval
//                modport slave  = scheduler, modport master = host + engines
//  Revision    : 1.0  initial release
// ============================================================================
interface eval_scheduler_if
  import eval_pkg::*;
#(
  parameter int NUM_ENGINES = 2
);

  logic                              start;
  logic                              is_max;
  logic [7:0]                        batch_size;
  logic [BATCH_BITS-1:0]             batch;
  logic [NUM_ENGINES*BOARD_BITS-1:0] eng_board;
  logic [NUM_ENGINES-1:0]            eng_enable;
  logic [NUM_ENGINES-1:0]            eng_reset;
  logic [NUM_ENGINES-1:0]            eng_stable;
  logic [NUM_ENGINES*EVAL_WIDTH-1:0] eng_eval;
  logic                              busy;
  logic                              done;
  logic [EVAL_WIDTH-1:0]             result;
  logic                              result_valid;
  logic                              err;

  modport slave (
    input  start, is_max, batch_size, batch, eng_stable, eng_eval,
    output eng_board, eng_enable, eng_reset, busy, done, result,
           result_valid, err
  );

  modport master (
    output start, is_max, batch_size, batch, eng_stable, eng_eval,
    input  eng_board, eng_enable, eng_reset, busy, done, result,
           result_valid, err
  );

endinterface
`default_nettype wire

// File: rtl/eval_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : eval_reducer
//  Description : Running signed max/min of captured engine evaluations.
//                The first capture after a clear always loads the register.
//  Ports       : clk, reset (sync, active low)
//                i_clear   - forget the running value (new batch)
//                i_capture - i_value is a new evaluation
//                i_is_max  - 1: keep maximum, 0: keep minimum
//                i_value   - signed evaluation
//                o_best    - current best (0 when nothing captured)
//  Revision    : 1.0  initial release
// ============================================================================
module eval_reducer
  import eval_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_capture,
  input  logic                         i_is_max,
  input  logic signed [EVAL_WIDTH-1:0] i_value,
  output logic signed [EVAL_WIDTH-1:0] o_best
);

  logic                         r_have;
  logic signed [EVAL_WIDTH-1:0] r_best;
  logic                         w_take;

  assign w_take = i_capture && (!r_have || beats(i_value, r_best, i_is_max));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_have <= 1'b0;
      r_best <= '0;
    end else if (i_clear) begin
      r_have <= 1'b0;
      r_best <= '0;
    end else if (w_take) begin
      r_have <= 1'b1;
      r_best <= i_value;
    end
  end

  assign o_best = r_best;

endmodule
`default_nettype wire

// File: rtl/eval_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : eval_scheduler
//  Description : Shares NUM_ENGINES board-evaluation engines across a batch of
//                up to MAX_BOARDS boards. Dispatches boards in order to the
//                lowest free engine, captures from the lowest stable busy
//                engine, recycles each engine with a one-cycle reset pulse and
//                reduces the captured evaluations to a signed max or min.
//  Ports       : clk, reset (sync, active low)
//                bus  - eval_scheduler_if.slave (host request/status and
//                       per-engine board/enable/reset/stable/eval)
//  Parameters  : NUM_ENGINES (1..7), TIMEOUT (cycles one engine may run)
//  Revision    : 1.0  initial release
// ============================================================================
module eval_scheduler
  import eval_pkg::*;
#(
  parameter int NUM_ENGINES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic            clk,
  input  logic            reset,
  eval_scheduler_if.slave bus
);

  localparam int             IW       = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  sched_state_t                      r_state;
  logic                              r_busy;
  logic                              r_done;
  logic [EVAL_WIDTH-1:0]             r_result;
  logic                              r_result_valid;
  logic                              r_err;
  logic [NUM_ENGINES-1:0]            r_eng_enable;
  logic [NUM_ENGINES-1:0]            r_eng_reset;
  logic [NUM_ENGINES*BOARD_BITS-1:0] r_eng_board;
  logic                              r_is_max;
  logic [3:0]                        r_size;
  logic [3:0]                        r_next;
  logic [3:0]                        r_capt;
  logic [BOARD_BITS-1:0]             r_boards [MAX_BOARDS];
  eng_state_t                        r_eng_st [NUM_ENGINES];
  logic [TW-1:0]                     r_tmo    [NUM_ENGINES];

  logic                         w_accept;
  logic                         w_dsp_valid;
  logic [IW-1:0]                w_dsp_idx;
  logic                         w_cap_valid;
  logic [IW-1:0]                w_cap_idx;
  logic                         w_tmo_hit;
  logic                         w_capture;
  logic signed [EVAL_WIDTH-1:0] w_cap_val;
  logic signed [EVAL_WIDTH-1:0] w_best;

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_capture = (r_state == S_RUN) && w_cap_valid && !w_tmo_hit;
  assign w_cap_val = bus.eng_eval[EVAL_WIDTH*int'(w_cap_idx) +: EVAL_WIDTH];

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    w_dsp_valid = 1'b0;
    w_dsp_idx   = '0;
    w_cap_valid = 1'b0;
    w_cap_idx   = '0;
    w_tmo_hit   = 1'b0;
    for (int e = NUM_ENGINES - 1; e >= 0; e--) begin
      if (r_eng_st[e] == ENG_FREE) begin
        w_dsp_valid = 1'b1;
        w_dsp_idx   = IW'(e);
      end
      if ((r_eng_st[e] == ENG_BUSY) && bus.eng_stable[e]) begin
        w_cap_valid = 1'b1;
        w_cap_idx   = IW'(e);
      end
    end
    w_dsp_valid = w_dsp_valid && (r_next < r_size);
    // An engine that is being captured on this edge delivered in time.
    for (int e = 0; e < NUM_ENGINES; e++) begin
      if ((r_eng_st[e] == ENG_BUSY) && (r_tmo[e] == TMO_LAST) &&
          !(w_cap_valid && (w_cap_idx == IW'(e)))) begin
        w_tmo_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_eng_enable   <= '0;
      r_eng_reset    <= '0;
      r_eng_board    <= '0;
      r_is_max       <= 1'b0;
      r_size         <= '0;
      r_next         <= '0;
      r_capt         <= '0;
      for (int e = 0; e < NUM_ENGINES; e++) begin
        r_eng_st[e] <= ENG_FREE;
        r_tmo[e]    <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_eng_enable <= '0;
          r_eng_reset  <= '1;
          if (w_accept) begin
            for (int k = 0; k < MAX_BOARDS; k++) begin
              r_boards[k] <= bus.batch[k*SLOT_BITS +: BOARD_BITS];
            end
            for (int e = 0; e < NUM_ENGINES; e++) begin
              r_eng_st[e] <= ENG_FREE;
              r_tmo[e]    <= '0;
            end
            r_is_max       <= bus.is_max;
            r_size         <= bus.batch_size[3:0];
            r_next         <= '0;
            r_capt         <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b1;
            if (bus.batch_size == 8'd0) begin
              r_err   <= 1'b0;
              r_state <= S_FINISH;
            end else if (bus.batch_size > 8'(MAX_BOARDS)) begin
              r_err   <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_err   <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (w_tmo_hit) begin
            r_err        <= 1'b1;
            r_eng_enable <= '0;
            r_eng_reset  <= '0;
            r_state      <= S_FINISH;
          end else begin
            for (int e = 0; e < NUM_ENGINES; e++) begin
              if (r_eng_st[e] == ENG_BUSY) begin
                r_tmo[e] <= r_tmo[e] + 1'b1;
              end
              if (r_eng_st[e] == ENG_RECYCLE) begin
                r_eng_reset[e] <= 1'b1;
                r_eng_st[e]    <= ENG_FREE;
              end
            end
            // Dispatch targets a FREE engine, capture a BUSY one, so the two
            // never collide on the same engine.
            if (w_dsp_valid) begin
              r_eng_board[BOARD_BITS*int'(w_dsp_idx) +: BOARD_BITS] <= r_boards[r_next[2:0]];
              r_eng_enable[w_dsp_idx] <= 1'b1;
              r_eng_st[w_dsp_idx]     <= ENG_BUSY;
              r_tmo[w_dsp_idx]        <= '0;
              r_next                  <= r_next + 4'd1;
            end
            if (w_cap_valid) begin
              r_eng_enable[w_cap_idx] <= 1'b0;
              r_eng_reset[w_cap_idx]  <= 1'b0;
              r_eng_st[w_cap_idx]     <= ENG_RECYCLE;
              r_capt                  <= r_capt + 4'd1;
              if ((r_capt + 4'd1) == r_size) begin
                r_state <= S_FINISH;
              end
            end
          end
        end

        S_FINISH: begin
          r_result       <= r_err ? '0 : w_best;
          r_result_valid <= 1'b1;
          r_done         <= 1'b1;
          r_busy         <= 1'b0;
          r_eng_enable   <= '0;
          r_eng_reset    <= '1;
          for (int e = 0; e < NUM_ENGINES; e++) begin
            r_eng_st[e] <= ENG_FREE;
          end
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  eval_reducer u_reducer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_capture (w_capture),
    .i_is_max  (r_is_max),
    .i_value   (w_cap_val),
    .o_best    (w_best)
  );

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.err          = r_err;
  assign bus.eng_enable   = r_eng_enable;
  assign bus.eng_reset    = r_eng_reset;
  assign bus.eng_board    = r_eng_board;

endmodule
`default_nettype wire
